// File: rtl/line_repair_arbiter_pkg.sv
// Shared types and constants for the cache line repair arbiter.
package line_repair_arbiter_pkg;

  localparam int WORD_W        = 32;
  localparam int LINE_OFFSET_W = 7;
  localparam int LINE_BYTES    = 1 << LINE_OFFSET_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DELIVER = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Clear the byte offset within a line to get the line base address.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~(32'(LINE_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/line_repair_arbiter_if.sv
// Arbiter <-> cache controller signal bundle.
// Handshake semantics: requests are levels sampled in IDLE; *_req_acq,
// raddr_valid, waddr_valid, sent_repair and repair_resolved are one-cycle
// pulses with no back-pressure; rdata_valid qualifies rdata for exactly one
// cycle and is only accepted while a beat is outstanding.
interface ArbiterControllerIF #(parameter int LINE_WORDS = 32);
  logic                      read_repair_request;
  logic                      write_repair_request;
  logic [31:0]               missed_addr;
  logic [31:0]               rdata;
  logic                      rdata_valid;
  logic                      read_repair_req_acq;
  logic                      write_repair_req_acq;
  logic                      raddr_valid;
  logic [31:0]               raddr;
  logic                      waddr_valid;
  logic [31:0]               waddr;
  logic [32*LINE_WORDS-1:0]  wdata;
  logic [4*LINE_WORDS-1:0]   wmask;
  logic                      sent_repair;
  logic                      repair_resolved;

  modport Arbiter (
    input  read_repair_request, write_repair_request, missed_addr, rdata, rdata_valid,
    output read_repair_req_acq, write_repair_req_acq, raddr_valid, raddr,
           waddr_valid, waddr, wdata, wmask, sent_repair, repair_resolved
  );

  modport Controller (
    output read_repair_request, write_repair_request, missed_addr, rdata, rdata_valid,
    input  read_repair_req_acq, write_repair_req_acq, raddr_valid, raddr,
           waddr_valid, waddr, wdata, wmask, sent_repair, repair_resolved
  );
endinterface

// File: rtl/line_repair_arbiter_line_assembler.sv
// Beat counter and line buffer: collects one word per accepted beat.
module line_assembler
  import line_repair_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 32,
  parameter int BW         = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         wr_en_i,
  input  logic [WORD_W-1:0]            word_i,
  output logic [BW-1:0]                beat_o,
  output logic                         last_o,
  output logic [WORD_W*LINE_WORDS-1:0] line_o
);

  logic [BW-1:0]                beat_q;
  logic [WORD_W*LINE_WORDS-1:0] line_q;
  logic [LINE_WORDS-1:0]        we_d;

  assign beat_o = beat_q;
  assign last_o = (beat_q == BW'(LINE_WORDS - 1));
  assign line_o = line_q;

  // Decode the current beat into a one-hot word write enable.
  always_comb begin
    we_d = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      we_d[i] = wr_en_i && (beat_q == BW'(i));
    end
  end

  // Beat counter: holds at the last beat so it never wraps into a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (clear_i) begin
      beat_q <= '0;
    end else if (wr_en_i && !last_o) begin
      beat_q <= beat_q + BW'(1);
    end
  end

  // Line buffer: word i lands in bits [32i+31:32i].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (clear_i) begin
      line_q <= '0;
    end else begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (we_d[i]) line_q[WORD_W*i +: WORD_W] <= word_i;
      end
    end
  end

endmodule

// File: rtl/line_repair_arbiter.sv
// Arbitrates read/write line repairs, fetches a line beat by beat with
// timeout reissue, then delivers the assembled line to the controller.
module line_repair_arbiter
  import line_repair_arbiter_pkg::*;
#(
  parameter int LINE_WORDS   = 32,
  parameter int BEAT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  ArbiterControllerIF.Arbiter bus,
  output state_e              state_o
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam int TW = $clog2(BEAT_TIMEOUT + 1);

  state_e                       state_q, state_d;
  logic [31:0]                  base_q, raddr_q, waddr_q;
  logic [32*LINE_WORDS-1:0]     wdata_q;
  logic                         grant_read_q, last_write_q;
  logic                         issue_q;
  logic [TW-1:0]                timer_q;
  logic [BW-1:0]                beat;
  logic                         last_beat;
  logic [32*LINE_WORDS-1:0]     line;
  logic                         pick_read, take_beat, timeout;

  assign state_o   = state_q;
  // Round-robin: on a tie grant the type that was not granted last.
  assign pick_read = bus.read_repair_request && (!bus.write_repair_request || last_write_q);
  // A beat is outstanding in FETCH on every cycle other than the issue cycle.
  assign take_beat = (state_q == ST_FETCH) && !issue_q && bus.rdata_valid;
  assign timeout   = (state_q == ST_FETCH) && !issue_q && !bus.rdata_valid &&
                     (timer_q == TW'(BEAT_TIMEOUT - 1));

  line_assembler #(.LINE_WORDS(LINE_WORDS)) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == ST_GRANT),
    .wr_en_i (take_beat),
    .word_i  (bus.rdata),
    .beat_o  (beat),
    .last_o  (last_beat),
    .line_o  (line)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.read_repair_request || bus.write_repair_request) state_d = ST_GRANT;
      ST_GRANT:   state_d = ST_FETCH;
      ST_FETCH:   if (take_beat && last_beat) state_d = ST_DELIVER;
      ST_DELIVER: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: grant bookkeeping, beat issue/timeout, held addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      grant_read_q <= 1'b0;
      last_write_q <= 1'b1;
      issue_q      <= 1'b0;
      timer_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (state_d == ST_GRANT) begin
            grant_read_q <= pick_read;
            last_write_q <= !pick_read;
            base_q       <= line_base(bus.missed_addr);
          end
        end
        ST_GRANT: begin
          raddr_q <= base_q;
          issue_q <= 1'b1;
          timer_q <= '0;
        end
        ST_FETCH: begin
          if (issue_q) begin
            issue_q <= 1'b0;
            timer_q <= '0;
          end else if (take_beat) begin
            if (last_beat) begin
              waddr_q <= base_q;
            end else begin
              issue_q <= 1'b1;
              raddr_q <= base_q + ((32'(beat) + 32'd1) << 2);
            end
          end else if (timeout) begin
            issue_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DELIVER: begin
          wdata_q <= line;
          issue_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output decode: pulses from the current state, held values otherwise.
  always_comb begin
    bus.read_repair_req_acq  = (state_q == ST_GRANT) && grant_read_q;
    bus.write_repair_req_acq = (state_q == ST_GRANT) && !grant_read_q;
    bus.raddr_valid          = (state_q == ST_FETCH) && issue_q;
    bus.raddr                = raddr_q;
    bus.waddr_valid          = (state_q == ST_DELIVER);
    bus.waddr                = waddr_q;
    bus.wdata                = (state_q == ST_DELIVER) ? line : wdata_q;
    bus.wmask                = (state_q == ST_DELIVER) ? '1 : '0;
    bus.sent_repair          = (state_q == ST_DELIVER);
    bus.repair_resolved      = (state_q == ST_DONE);
  end

endmodule
